// File: rtl/ring_osc_reader.sv
// Sequencer that gates a ring oscillator, snapshots its 15-bit counter before and after
// an enable window, and reports the count delta. Define RO_READER_SWEEP_EN to sweep taps 0..7.
module ring_osc_reader #(
    parameter int WIN_W      = 16,
    parameter int SETTLE     = 4,
    parameter int STABLE_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       tap_sel,
    input  logic [WIN_W-1:0] window_cycles,
    input  logic             test_mode_req,
    output logic             osc_enable,
    output logic [2:0]       osc_tap,
    output logic             osc_test_mode,
    input  logic [6:0]       cnt_lo,
    input  logic [7:0]       cnt_hi,
    output logic [14:0]      result,
    output logic [2:0]       result_tap,
    output logic             result_err,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    localparam int TMO_LAST = SETTLE + STABLE_MAX - 1;
    localparam int TMO_W    = $clog2(TMO_LAST + 2);
    localparam int CNT_W    = (WIN_W > TMO_W) ? WIN_W : TMO_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BASE,
        ST_WINDOW,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   phase_cnt_reg;
    logic [14:0]        sync1_reg, sync2_reg, prev_reg;
    logic [14:0]        base_reg;
    logic [WIN_W-1:0]   win_len_reg;
    logic [2:0]         tap_reg;
    logic               test_mode_reg;
    logic               osc_enable_reg;
    logic [14:0]        result_reg;
    logic [2:0]         result_tap_reg;
    logic               result_err_reg;

    logic               stable;
    logic               capture;
    logic               base_load;
    logic               res_load;
    logic               res_err;
    logic               tap_advance;

    // The counter is asynchronous to clk; a value is trusted only once it repeats.
    assign stable = (sync2_reg == prev_reg);

    always_comb begin
        state_next  = state_reg;
        capture     = 1'b0;
        base_load   = 1'b0;
        res_load    = 1'b0;
        res_err     = 1'b0;
        tap_advance = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = ST_BASE;
                end
            end
            ST_BASE: begin
                if (phase_cnt_reg >= CNT_W'(SETTLE)) begin
                    if (stable) begin
                        base_load  = 1'b1;
                        state_next = (win_len_reg == '0) ? ST_SETTLE : ST_WINDOW;
                    end else if (phase_cnt_reg == CNT_W'(TMO_LAST)) begin
                        res_load   = 1'b1;
                        res_err    = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_WINDOW: begin
                if (phase_cnt_reg == CNT_W'(win_len_reg) - CNT_W'(1))
                    state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if ((phase_cnt_reg + CNT_W'(1)) >= CNT_W'(SETTLE))
                    state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (stable) begin
                    res_load   = 1'b1;
                    state_next = ST_DONE;
                end else if (phase_cnt_reg == CNT_W'(STABLE_MAX - 1)) begin
                    res_load   = 1'b1;
                    res_err    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
`ifdef RO_READER_SWEEP_EN
                    if (tap_reg == 3'd7) begin
                        state_next = ST_IDLE;
                    end else begin
                        tap_advance = 1'b1;
                        state_next  = ST_BASE;
                    end
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef RO_READER_SWEEP_EN
    logic unused_tap_sel;
    assign unused_tap_sel = ^tap_sel;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            phase_cnt_reg  <= '0;
            sync1_reg      <= '0;
            sync2_reg      <= '0;
            prev_reg       <= '0;
            base_reg       <= '0;
            win_len_reg    <= '0;
            tap_reg        <= '0;
            test_mode_reg  <= 1'b0;
            osc_enable_reg <= 1'b0;
            result_reg     <= '0;
            result_tap_reg <= '0;
            result_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            sync1_reg <= {cnt_hi, cnt_lo};
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            // Phase counter restarts on every state change so each state times itself.
            if (state_next != state_reg || state_reg == ST_IDLE || state_reg == ST_DONE)
                phase_cnt_reg <= '0;
            else
                phase_cnt_reg <= phase_cnt_reg + CNT_W'(1);
            osc_enable_reg <= (state_next == ST_WINDOW);
            if (capture) begin
`ifdef RO_READER_SWEEP_EN
                tap_reg <= 3'd0;
`else
                tap_reg <= tap_sel;
`endif
                win_len_reg   <= window_cycles;
                test_mode_reg <= test_mode_req;
            end
            if (tap_advance)
                tap_reg <= tap_reg + 3'd1;
            if (base_load)
                base_reg <= sync2_reg;
            if (res_load) begin
                result_reg     <= res_err ? 15'd0 : (sync2_reg - base_reg);
                result_tap_reg <= tap_reg;
                result_err_reg <= res_err;
            end
        end
    end

    assign osc_enable    = osc_enable_reg;
    assign osc_tap       = tap_reg;
    assign osc_test_mode = test_mode_reg;
    assign result        = result_reg;
    assign result_tap    = result_tap_reg;
    assign result_err    = result_err_reg;
    assign result_valid  = (state_reg == ST_DONE);
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ring_osc_reader.sv
// Directed bench for ring_osc_reader with a behavioural oscillator counter model.
module tb_ring_osc_reader;

    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  tap_sel;
    logic [15:0] window_cycles;
    logic        test_mode_req;
    logic        osc_enable;
    logic [2:0]  osc_tap;
    logic        osc_test_mode;
    logic [6:0]  cnt_lo;
    logic [7:0]  cnt_hi;
    logic [14:0] result;
    logic [2:0]  result_tap;
    logic        result_err;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    logic [14:0] cnt_model = 15'd0;
    logic        load_en   = 1'b0;
    logic [14:0] load_val  = 15'd0;
    logic        toggle_md = 1'b0;

    int total = 0;
    int bad   = 0;

    ring_osc_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .tap_sel       (tap_sel),
        .window_cycles (window_cycles),
        .test_mode_req (test_mode_req),
        .osc_enable    (osc_enable),
        .osc_tap       (osc_tap),
        .osc_test_mode (osc_test_mode),
        .cnt_lo        (cnt_lo),
        .cnt_hi        (cnt_hi),
        .result        (result),
        .result_tap    (result_tap),
        .result_err    (result_err),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Oscillator counter model: counts one per clk while enabled.
    always @(posedge clk) begin
        if (load_en)
            cnt_model <= load_val;
        else if (toggle_md)
            cnt_model <= cnt_model ^ 15'h0001;
        else if (osc_enable)
            cnt_model <= cnt_model + 15'd1;
    end

    assign cnt_lo = cnt_model[6:0];
    assign cnt_hi = cnt_model[14:7];

    task automatic set_model(input logic [14:0] val, input logic tog);
        @(negedge clk);
        load_en   = 1'b1;
        load_val  = val;
        toggle_md = tog;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic wait_valid(output int cycles, output int en_cnt, output bit timed_out);
        cycles = 0;
        en_cnt = 0;
        while (!result_valid && cycles < LIMIT) begin
            if (osc_enable) en_cnt++;
            @(negedge clk);
            cycles++;
        end
        timed_out = !result_valid;
    endtask

    task automatic run_meas(input logic [2:0] tap, input logic [15:0] win, input logic tm,
                            output int cycles, output int en_cnt, output bit timed_out);
        @(negedge clk);
        tap_sel       = tap;
        window_cycles = win;
        test_mode_req = tm;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(cycles, en_cnt, timed_out);
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 8;
        if (osc_enable !== 1'b0)     begin bad++; $display("FAIL reset_osc_enable got=%b exp=0", osc_enable); end
        if (osc_tap !== 3'd0)        begin bad++; $display("FAIL reset_osc_tap got=%0d exp=0", osc_tap); end
        if (osc_test_mode !== 1'b0)  begin bad++; $display("FAIL reset_test_mode got=%b exp=0", osc_test_mode); end
        if (result !== 15'd0)        begin bad++; $display("FAIL reset_result got=%0d exp=0", result); end
        if (result_tap !== 3'd0)     begin bad++; $display("FAIL reset_result_tap got=%0d exp=0", result_tap); end
        if (result_err !== 1'b0)     begin bad++; $display("FAIL reset_result_err got=%b exp=0", result_err); end
        if (result_valid !== 1'b0)   begin bad++; $display("FAIL reset_result_valid got=%b exp=0", result_valid); end
        if (busy !== 1'b0)           begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: checked idle outputs");
    endtask

    task automatic test_basic();
        int cyc, en; bit to;
        set_model(15'd0, 1'b0);
        run_meas(3'd5, 16'd100, 1'b0, cyc, en, to);
        total += 5;
        if (to)                  begin bad++; $display("FAIL basic_timeout waited=%0d cycles without result_valid", cyc); end
        if (result !== 15'd100)  begin bad++; $display("FAIL basic_result got=%0d exp=100", result); end
        if (result_tap !== 3'd5) begin bad++; $display("FAIL basic_tap got=%0d exp=5", result_tap); end
        if (result_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", result_err); end
        if (en !== 100)          begin bad++; $display("FAIL basic_enable_cycles got=%0d exp=100", en); end
        accept();
        total++;
        if (busy !== 1'b0)       begin bad++; $display("FAIL basic_busy_after_accept got=%b exp=0", busy); end
        $display("basic: tap=%0d result=%0d err=%b en=%0d", result_tap, result, result_err, en);
    endtask

    task automatic test_wrap();
        int cyc, en; bit to;
        set_model(15'h7FF0, 1'b0);
        run_meas(3'd2, 16'd32, 1'b0, cyc, en, to);
        total += 3;
        if (to)                  begin bad++; $display("FAIL wrap_timeout waited=%0d", cyc); end
        if (result !== 15'd32)   begin bad++; $display("FAIL wrap_result got=%0d exp=32", result); end
        if (result_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b exp=0", result_err); end
        accept();
        $display("wrap: result=%0d model=%h", result, cnt_model);
    endtask

    task automatic test_zero_window();
        int cyc, en; bit to;
        set_model(15'd123, 1'b0);
        run_meas(3'd1, 16'd0, 1'b0, cyc, en, to);
        total += 4;
        if (to)                  begin bad++; $display("FAIL zero_timeout waited=%0d", cyc); end
        if (result !== 15'd0)    begin bad++; $display("FAIL zero_result got=%0d exp=0", result); end
        if (result_err !== 1'b0) begin bad++; $display("FAIL zero_err got=%b exp=0", result_err); end
        if (en !== 0)            begin bad++; $display("FAIL zero_enable_cycles got=%0d exp=0", en); end
        accept();
        $display("zero_window: result=%0d en=%0d", result, en);
    endtask

    task automatic test_timeout();
        int cyc, en; bit to;
        set_model(15'd0, 1'b1);
        run_meas(3'd4, 16'd50, 1'b0, cyc, en, to);
        total += 5;
        if (to)                  begin bad++; $display("FAIL tmo_no_result waited=%0d", cyc); end
        if (result_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", result_err); end
        if (result !== 15'd0)    begin bad++; $display("FAIL tmo_result got=%0d exp=0", result); end
        if (cyc > 4 + 2 + 255)   begin bad++; $display("FAIL tmo_latency got=%0d exp<=261", cyc); end
        if (en !== 0)            begin bad++; $display("FAIL tmo_enable_cycles got=%0d exp=0", en); end
        accept();
        set_model(15'd0, 1'b0);
        $display("timeout: err=%b result=%0d cycles=%0d", result_err, result, cyc);
    endtask

    task automatic test_hold();
        int cyc, en; bit to;
        set_model(15'd500, 1'b0);
        run_meas(3'd3, 16'd20, 1'b1, cyc, en, to);
        total++;
        if (to) begin bad++; $display("FAIL hold_timeout waited=%0d", cyc); end
        for (int i = 0; i < 10; i++) begin
            tap_sel = 3'd6;
            test_mode_req = 1'b0;
            start = (i == 2 || i == 5);
            @(negedge clk);
            start = 1'b0;
            total += 5;
            if (result !== 15'd20)      begin bad++; $display("FAIL hold_result cyc=%0d got=%0d exp=20", i, result); end
            if (result_valid !== 1'b1)  begin bad++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, result_valid); end
            if (result_tap !== 3'd3)    begin bad++; $display("FAIL hold_tap cyc=%0d got=%0d exp=3", i, result_tap); end
            if (osc_tap !== 3'd3)       begin bad++; $display("FAIL hold_osc_tap cyc=%0d got=%0d exp=3", i, osc_tap); end
            if (osc_test_mode !== 1'b1) begin bad++; $display("FAIL hold_test_mode cyc=%0d got=%b exp=1", i, osc_test_mode); end
        end
        accept();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy_after_accept got=%b exp=0", busy); end
        $display("hold: result=%0d tap=%0d kept for 10 cycles", result, result_tap);
    endtask

    task automatic test_reset_mid_window();
        int n;
        bit seen;
        set_model(15'd0, 1'b0);
        @(negedge clk);
        tap_sel = 3'd7; window_cycles = 16'd1000; test_mode_req = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!osc_enable && n < 50) begin @(negedge clk); n++; end
        total++;
        if (!osc_enable) begin bad++; $display("FAIL midrst_no_window got=%b exp=1", osc_enable); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total += 3;
        if (osc_enable !== 1'b0)   begin bad++; $display("FAIL midrst_osc_enable got=%b exp=0", osc_enable); end
        if (busy !== 1'b0)         begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (osc_tap !== 3'd0)      begin bad++; $display("FAIL midrst_osc_tap got=%0d exp=0", osc_tap); end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid || osc_enable) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL midrst_activity got=%b exp=0", seen); end
        $display("reset_mid_window: enable dropped, no result");
    endtask

    task automatic test_back_to_back();
        int cyc, en; bit to;
        set_model(15'd1000, 1'b0);
        run_meas(3'd1, 16'd7, 1'b0, cyc, en, to);
        total += 3;
        if (to)                  begin bad++; $display("FAIL b2b1_timeout waited=%0d", cyc); end
        if (result !== 15'd7)    begin bad++; $display("FAIL b2b1_result got=%0d exp=7", result); end
        if (result_tap !== 3'd1) begin bad++; $display("FAIL b2b1_tap got=%0d exp=1", result_tap); end
        $display("back_to_back#1: tap=%0d result=%0d", result_tap, result);
        accept();
        run_meas(3'd2, 16'd9, 1'b0, cyc, en, to);
        total += 3;
        if (to)                  begin bad++; $display("FAIL b2b2_timeout waited=%0d", cyc); end
        if (result !== 15'd9)    begin bad++; $display("FAIL b2b2_result got=%0d exp=9", result); end
        if (result_tap !== 3'd2) begin bad++; $display("FAIL b2b2_tap got=%0d exp=2", result_tap); end
        $display("back_to_back#2: tap=%0d result=%0d", result_tap, result);
        accept();
    endtask

    task automatic test_sweep();
        int cyc, en; bit to;
        set_model(15'd0, 1'b0);
        @(negedge clk);
        tap_sel = 3'd5; window_cycles = 16'd10; test_mode_req = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 8; t++) begin
            wait_valid(cyc, en, to);
            total += 4;
            if (to)                      begin bad++; $display("FAIL sweep_timeout tap=%0d waited=%0d", t, cyc); end
            if (result !== 15'd10)       begin bad++; $display("FAIL sweep_result tap=%0d got=%0d exp=10", t, result); end
            if (result_tap !== 3'(t))    begin bad++; $display("FAIL sweep_tap got=%0d exp=%0d", result_tap, t); end
            if (busy !== 1'b1)           begin bad++; $display("FAIL sweep_busy tap=%0d got=%b exp=1", t, busy); end
            $display("sweep: tap=%0d result=%0d", result_tap, result);
            accept();
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL sweep_busy_end got=%b exp=0", busy); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        tap_sel = 3'd0;
        window_cycles = 16'd0;
        test_mode_req = 1'b0;
        result_ready = 1'b0;
        test_reset();
`ifdef RO_READER_SWEEP_EN
        test_sweep();
`else
        test_basic();
        test_wrap();
        test_zero_window();
        test_timeout();
        test_hold();
        test_back_to_back();
        test_reset_mid_window();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_osc_reader.md
RING_OSC_READER -- requirements
Module: ring_osc_reader

Interface
REQ-001 Parameter WIN_W, default 16: width of measurement-window length in clk cycles.
REQ-002 Parameter SETTLE, default 4: clk cycles waited after osc_enable falls before count sampling starts.
REQ-003 Parameter STABLE_MAX, default 255: maximum sampling cycles allowed before stability timeout.
REQ-004 clk  in  1  system clock; all flops on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin a measurement; accepted only in IDLE.
REQ-007 tap_sel  in  3  ring tap to measure; captured at start acceptance.
REQ-008 window_cycles  in  WIN_W  enable-window length; captured at start acceptance.
REQ-009 test_mode_req  in  1  requests oscillator test mode (counter clocked by clk); captured at start.
REQ-010 osc_enable  out  1  drives oscillator enable (ui_in[0]).
REQ-011 osc_tap  out  3  drives tap select (ui_in[3:1]).
REQ-012 osc_test_mode  out  1  drives test mode (ui_in[4]).
REQ-013 cnt_lo  in  7  count bits [6:0] from oscillator uo_out[7:1].
REQ-014 cnt_hi  in  8  count bits [14:7] from oscillator uio_out[7:0].
REQ-015 result  out  15  measured count delta.
REQ-016 result_tap  out  3  tap the result belongs to.
REQ-017 result_err  out  1  set with result_valid when a stability timeout occurred.
REQ-018 result_valid  out  1  result available; held until accepted.
REQ-019 result_ready  in  1  consumer accepts when result_valid and result_ready both high.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 {cnt_hi,cnt_lo} SHALL pass through a 2-flop synchronizer; "stable" = synchronized value identical on two consecutive cycles.
REQ-022 FSM states IDLE, BASE, WINDOW, SETTLE, SAMPLE, DONE.
REQ-023 IDLE: on start, capture tap_sel/window_cycles/test_mode_req, drive osc_tap/osc_test_mode from captured values, go BASE.
REQ-024 BASE: osc_enable=0; wait SETTLE cycles, then first stable value is latched as baseline; go WINDOW.
REQ-025 WINDOW: osc_enable=1 for exactly window_cycles consecutive cycles; window_cycles=0 skips WINDOW with no enable pulse.
REQ-026 SETTLE: osc_enable=0 for SETTLE cycles, then SAMPLE.
REQ-027 SAMPLE: first stable value is final; result = (final - baseline) mod 2^15; go DONE.
REQ-028 Counter wrap: modulo subtraction SHALL give the correct delta for any single wrap (delta < 2^15).
REQ-029 Timeout: if BASE or SAMPLE sees no stable value within STABLE_MAX cycles, go DONE with result=0, result_err=1.
REQ-030 DONE: result_valid=1; result/result_tap/result_err held constant until handshake; handshake returns to IDLE next cycle.
REQ-031 start outside IDLE SHALL be ignored; osc_tap/osc_test_mode SHALL NOT change outside IDLE.

Reset
REQ-032 rst_n low at a clk edge: state=IDLE, osc_enable=0, osc_tap=0, osc_test_mode=0, result=0, result_tap=0, result_err=0, result_valid=0, busy=0, synchronizer and baseline cleared.
REQ-033 Reset asserted mid-WINDOW SHALL drop osc_enable on that same clk edge; no result is produced for the aborted measurement.

Configuration
REQ-034 Macro RO_READER_SWEEP_EN defined: tap_sel ignored; one start measures taps 0..7 in order, each producing one result handshake, returning to IDLE only after tap 7 accepted; busy high throughout.
REQ-035 RO_READER_SWEEP_EN undefined: exactly one measurement per start, at captured tap_sel.

Verification
REQ-036 Counter model increments per clk while osc_enable=1, baseline 0; window_cycles=100, tap 5 -> result=100, result_tap=5, result_err=0.
REQ-037 Model count preset 0x7FF0, window_cycles=32 -> result=32 (wrap through 0).
REQ-038 window_cycles=0 -> osc_enable never high, result=0, result_err=0.
REQ-039 Model count toggles every cycle (never stable) -> result_valid with result_err=1, result=0 after at most SETTLE+2+STABLE_MAX cycles in BASE.
REQ-040 result_ready low 10 cycles in DONE -> result/result_valid constant; start pulses ignored; rst_n low in WINDOW -> osc_enable=0 next edge, busy=0.
REQ-041 RO_READER_SWEEP_EN, window_cycles=10 -> eight results, result_tap 0..7 in order, each result=10.
